// File: rtl/chx_pkt_buf.sv
// Store-and-forward packet buffer: bytes go into a FIFO and only whole committed packets are replayed.
// Define CHX_PKT_BUF_STAT_EN to implement the drop_cnt/err_cnt counters; otherwise both read as 0.
module chx_pkt_buf #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned PKT_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic        in_qos,
  input  logic        in_vld,
  input  logic [2:0]  in_id,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_qos,
  output logic [2:0]  out_id,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [15:0] drop_cnt,
  output logic [15:0] err_cnt
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = LW - 1;
  localparam int unsigned PW = $clog2(PKT_DEPTH) + 1;
  localparam int unsigned DW = 3 + 1 + LW;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_RECV = 2'd1;
  localparam logic [1:0] WR_DROP = 2'd2;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_SEND = 1'b1;

  logic [7:0]    mem [DEPTH];
  logic [DW-1:0] desc_mem [PKT_DEPTH];

  logic [1:0]    wr_st_q, wr_st_d;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d, len_q, len_d;
  logic [2:0]    wid_q, wid_d;
  logic          wqos_q, wqos_d;
  logic [PW-1:0] dwp_q, drp_q;
  logic [0:0]    rd_st_q, rd_st_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d, rem_q, rem_d;
  logic [2:0]    rid_q, rid_d;
  logic          rqos_q, rqos_d, first_q, first_d;
  logic          push, pop, mem_we, drop_inc, err_inc, sop_case;
  logic [AW-1:0] mem_waddr;
  logic [LW-1:0] base;
  logic          desc_full, desc_empty, byte_full;
  logic [DW-1:0] desc_rdata;

  assign desc_empty = (dwp_q == drp_q);
  assign desc_full  = ((dwp_q - drp_q) == PW'(PKT_DEPTH));
  assign byte_full  = ((wr_ptr_q - rd_ptr_q) == LW'(DEPTH));
  assign desc_rdata = desc_mem[drp_q[PW-2:0]];

  always_comb begin
    wr_st_d   = wr_st_q;
    wr_ptr_d  = wr_ptr_q;
    wr_cmt_d  = wr_cmt_q;
    len_d     = len_q;
    wid_d     = wid_q;
    wqos_d    = wqos_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q[AW-1:0];
    push      = 1'b0;
    drop_inc  = 1'b0;
    err_inc   = 1'b0;
    sop_case  = 1'b0;
    base      = wr_ptr_q;
    if (in_vld) begin
      case (wr_st_q)
        WR_IDLE: begin
          if (in_sop) sop_case = 1'b1;
          else        err_inc  = 1'b1;
        end
        WR_RECV: begin
          if (in_sop) begin
            // Missing eop: discard the open packet, then treat this beat as a fresh start.
            err_inc  = 1'b1;
            base     = wr_cmt_q;
            sop_case = 1'b1;
          end else if (byte_full) begin
            wr_ptr_d = wr_cmt_q;
            drop_inc = 1'b1;
            wr_st_d  = in_eop ? WR_IDLE : WR_DROP;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + LW'(1);
            len_d    = len_q + LW'(1);
            if (in_eop) begin
              push     = 1'b1;
              wr_cmt_d = wr_ptr_q + LW'(1);
              wr_st_d  = WR_IDLE;
            end
          end
        end
        WR_DROP: begin
          if (in_sop) begin
            err_inc  = 1'b1;
            sop_case = 1'b1;
          end else if (in_eop) begin
            wr_st_d = WR_IDLE;
          end
        end
        default: wr_st_d = WR_IDLE;
      endcase
      if (sop_case) begin
        wr_ptr_d = base;
        // A full byte FIFO at sop also drops, so unread data is never overwritten.
        if (desc_full || ((base - rd_ptr_q) == LW'(DEPTH))) begin
          drop_inc = 1'b1;
          wr_st_d  = in_eop ? WR_IDLE : WR_DROP;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = base[AW-1:0];
          wr_ptr_d  = base + LW'(1);
          len_d     = LW'(1);
          wid_d     = in_id;
          wqos_d    = in_qos;
          wr_st_d   = WR_RECV;
          if (in_eop) begin
            push     = 1'b1;
            wr_cmt_d = base + LW'(1);
            wr_st_d  = WR_IDLE;
          end
        end
      end
    end
  end

  always_comb begin
    rd_st_d  = rd_st_q;
    rd_ptr_d = rd_ptr_q;
    rem_d    = rem_q;
    rid_d    = rid_q;
    rqos_d   = rqos_q;
    first_d  = first_q;
    pop      = 1'b0;
    case (rd_st_q)
      RD_IDLE: pop = !desc_empty;
      default: begin
        if (out_rdy) begin
          rd_ptr_d = rd_ptr_q + LW'(1);
          rem_d    = rem_q - LW'(1);
          first_d  = 1'b0;
          if (rem_q == LW'(1)) begin
            pop = !desc_empty;
            if (desc_empty) rd_st_d = RD_IDLE;
          end
        end
      end
    endcase
    if (pop) begin
      rd_st_d = RD_SEND;
      rem_d   = desc_rdata[LW-1:0];
      rqos_d  = desc_rdata[LW];
      rid_d   = desc_rdata[LW+3:LW+1];
      first_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= in_data;
    if (push)   desc_mem[dwp_q[PW-2:0]] <= {wid_d, wqos_d, len_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_st_q  <= WR_IDLE;
      wr_ptr_q <= '0;
      wr_cmt_q <= '0;
      len_q    <= '0;
      wid_q    <= '0;
      wqos_q   <= 1'b0;
      dwp_q    <= '0;
      drp_q    <= '0;
      rd_st_q  <= RD_IDLE;
      rd_ptr_q <= '0;
      rem_q    <= '0;
      rid_q    <= '0;
      rqos_q   <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      wr_st_q  <= wr_st_d;
      wr_ptr_q <= wr_ptr_d;
      wr_cmt_q <= wr_cmt_d;
      len_q    <= len_d;
      wid_q    <= wid_d;
      wqos_q   <= wqos_d;
      dwp_q    <= dwp_q + PW'(push);
      drp_q    <= drp_q + PW'(pop);
      rd_st_q  <= rd_st_d;
      rd_ptr_q <= rd_ptr_d;
      rem_q    <= rem_d;
      rid_q    <= rid_d;
      rqos_q   <= rqos_d;
      first_q  <= first_d;
    end
  end

  assign out_vld  = (rd_st_q == RD_SEND);
  assign out_data = out_vld ? mem[rd_ptr_q[AW-1:0]] : 8'h00;
  assign out_sop  = out_vld & first_q;
  assign out_eop  = out_vld & (rem_q == LW'(1));
  assign out_qos  = out_vld & rqos_q;
  assign out_id   = out_vld ? rid_q : 3'd0;

`ifdef CHX_PKT_BUF_STAT_EN
  logic [15:0] drop_q, err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
      err_q  <= '0;
    end else begin
      if (drop_inc && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      if (err_inc && (err_q != 16'hFFFF))   err_q  <= err_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
  assign err_cnt  = err_q;
`else
  logic unused_stat;
  assign unused_stat = drop_inc ^ err_inc;
  assign drop_cnt    = '0;
  assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_chx_pkt_buf.sv
// Directed self-checking bench for chx_pkt_buf; counter expectations follow CHX_PKT_BUF_STAT_EN.
module tb_chx_pkt_buf;
  localparam int PKT_DEPTH = 8;
`ifdef CHX_PKT_BUF_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_sop = 1'b0, in_eop = 1'b0, in_qos = 1'b0, in_vld = 1'b0;
  logic [2:0]  in_id = '0;
  logic [7:0]  out_data;
  logic        out_sop, out_eop, out_qos, out_vld;
  logic [2:0]  out_id;
  logic        out_rdy = 1'b0;
  logic [15:0] drop_cnt, err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] q_data[$];
  logic       q_sop[$];
  logic       q_eop[$];
  logic       q_qos[$];
  logic [2:0] q_id[$];
  int         q_cyc[$];

  chx_pkt_buf #(.DEPTH(64), .PKT_DEPTH(PKT_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_qos(in_qos),
    .in_vld(in_vld), .in_id(in_id),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_qos(out_qos),
    .out_id(out_id), .out_vld(out_vld), .out_rdy(out_rdy),
    .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted output beat.
  always @(negedge clk) begin
    if (!rst && out_vld && out_rdy) begin
      q_data.push_back(out_data);
      q_sop.push_back(out_sop);
      q_eop.push_back(out_eop);
      q_qos.push_back(out_qos);
      q_id.push_back(out_id);
      q_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    repeat (n) tick();
  endtask

  task automatic beat(input logic [7:0] d, input logic s, input logic e, input logic q,
                      input logic [2:0] id);
    in_data = d; in_sop = s; in_eop = e; in_qos = q; in_id = id; in_vld = 1'b1;
    tick();
  endtask

  task automatic clear_q();
    q_data.delete(); q_sop.delete(); q_eop.delete();
    q_qos.delete(); q_id.delete(); q_cyc.delete();
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1; out_rdy = rdy;
    idle(2);
    rst = 1'b0;
    clear_q();
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    beat(8'hAA, 1'b1, 1'b1, 1'b1, 3'd7);
    idle(3);
    rst = 1'b1;
    beat(8'h55, 1'b1, 1'b0, 1'b1, 3'd2);
    @(negedge clk);
    checks++;
    if ({out_vld, out_sop, out_eop, out_qos, out_id, out_data} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%0b sop=%0b eop=%0b qos=%0b id=%0d data=%h want all 0",
               out_vld, out_sop, out_eop, out_qos, out_id, out_data);
    end
    checks++;
    if ({drop_cnt, err_cnt} !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got drop=%0d err=%0d want 0 0", drop_cnt, err_cnt);
    end
    tick();
    rst = 1'b0;
    in_vld = 1'b0;
  endtask

  task automatic test_single();
    int eop_cyc;
    do_reset(1'b1);
    beat(8'h11, 1'b1, 1'b0, 1'b1, 3'd5);
    beat(8'h12, 1'b0, 1'b0, 1'b0, 3'd0);
    beat(8'h13, 1'b0, 1'b0, 1'b0, 3'd0);
    eop_cyc = cyc;
    beat(8'h14, 1'b0, 1'b1, 1'b0, 3'd0);
    idle(8);
    checks++;
    if (q_data.size() !== 4) begin
      errors++;
      $display("FAIL single_count: got %0d beats want 4", q_data.size());
    end
    for (int i = 0; i < q_data.size() && i < 4; i++) begin
      checks++;
      if ({q_data[i], q_sop[i], q_eop[i], q_id[i], q_qos[i]} !==
          {8'h11 + 8'(i), i == 0, i == 3, 3'd5, 1'b1}) begin
        errors++;
        $display("FAIL single_beat%0d: got data=%h sop=%0b eop=%0b id=%0d qos=%0b want data=%h",
                 i, q_data[i], q_sop[i], q_eop[i], q_id[i], q_qos[i], 8'h11 + 8'(i));
      end
      checks++;
      if (q_cyc[i] !== eop_cyc + 2 + i) begin
        errors++;
        $display("FAIL single_timing%0d: got cycle %0d want %0d", i, q_cyc[i], eop_cyc + 2 + i);
      end
    end
    checks++;
    if ({drop_cnt, err_cnt} !== 32'd0) begin
      errors++;
      $display("FAIL single_counters: got drop=%0d err=%0d want 0 0", drop_cnt, err_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [13:0] snap;
    logic        stalled;
    logic        ph;
    int          acc;
    logic [2:0]  exp_id [6];
    logic        exp_qos [6];
    exp_id  = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3};
    exp_qos = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset(1'b0);
    beat(8'h21, 1'b1, 1'b0, 1'b0, 3'd1);
    beat(8'h22, 1'b0, 1'b1, 1'b0, 3'd1);
    beat(8'h23, 1'b1, 1'b0, 1'b1, 3'd2);
    beat(8'h24, 1'b0, 1'b1, 1'b1, 3'd2);
    beat(8'h25, 1'b1, 1'b0, 1'b0, 3'd3);
    beat(8'h26, 1'b0, 1'b1, 1'b0, 3'd3);
    idle(2);
    stalled = 1'b0; ph = 1'b1; acc = 0; snap = '0;
    for (int c = 0; c < 40 && acc < 6; c++) begin
      out_rdy = ph;
      @(negedge clk);
      checks++;
      if (out_vld !== 1'b1) begin
        errors++;
        $display("FAIL bp_bubble: got out_vld=%0b at accepted=%0d want 1", out_vld, acc);
      end
      if (stalled) begin
        checks++;
        if ({out_data, out_sop, out_eop, out_id, out_qos} !== snap) begin
          errors++;
          $display("FAIL bp_hold: got %h want %h", {out_data, out_sop, out_eop, out_id, out_qos},
                   snap);
        end
      end
      snap = {out_data, out_sop, out_eop, out_id, out_qos};
      stalled = !out_rdy;
      if (out_rdy && out_vld) acc++;
      tick();
      ph = !ph;
    end
    out_rdy = 1'b1;
    idle(3);
    checks++;
    if (q_data.size() !== 6) begin
      errors++;
      $display("FAIL bp_count: got %0d beats want 6", q_data.size());
    end
    for (int i = 0; i < q_data.size() && i < 6; i++) begin
      checks++;
      if ({q_data[i], q_sop[i], q_eop[i], q_id[i], q_qos[i]} !==
          {8'h21 + 8'(i), (i % 2) == 0, (i % 2) == 1, exp_id[i], exp_qos[i]}) begin
        errors++;
        $display("FAIL bp_beat%0d: got data=%h sop=%0b eop=%0b id=%0d qos=%0b want data=%h id=%0d",
                 i, q_data[i], q_sop[i], q_eop[i], q_id[i], q_qos[i], 8'h21 + 8'(i), exp_id[i]);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) beat(8'(i), i == 0, i == 39, 1'b0, 3'd4);
    for (int i = 0; i < 30; i++) beat(8'h80 + 8'(i), i == 0, i == 29, 1'b1, 3'd5);
    idle(3);
    checks++;
    if (drop_cnt !== (STAT ? 16'd1 : 16'd0) || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL ovf_counters: got drop=%0d err=%0d want drop=%0d err=0", drop_cnt, err_cnt,
               STAT ? 1 : 0);
    end
    out_rdy = 1'b1;
    idle(60);
    checks++;
    if (q_data.size() !== 40) begin
      errors++;
      $display("FAIL ovf_count: got %0d beats want 40", q_data.size());
    end
    for (int i = 0; i < q_data.size() && i < 40; i++) begin
      checks++;
      if ({q_data[i], q_sop[i], q_eop[i], q_id[i]} !== {8'(i), i == 0, i == 39, 3'd4}) begin
        errors++;
        $display("FAIL ovf_beat%0d: got data=%h sop=%0b eop=%0b id=%0d want data=%h id=4",
                 i, q_data[i], q_sop[i], q_eop[i], q_id[i], 8'(i));
      end
    end
  endtask

  task automatic test_desc_full();
    do_reset(1'b0);
    // The read side already holds one popped descriptor, so PKT_DEPTH+1 fit and the next drops.
    for (int i = 0; i < PKT_DEPTH + 2; i++) beat(8'h60 + 8'(i), 1'b1, 1'b1, 1'b0, 3'(i));
    idle(2);
    checks++;
    if (drop_cnt !== (STAT ? 16'd1 : 16'd0) || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL dfull_counters: got drop=%0d err=%0d want drop=%0d err=0", drop_cnt, err_cnt,
               STAT ? 1 : 0);
    end
    out_rdy = 1'b1;
    idle(20);
    checks++;
    if (q_data.size() !== PKT_DEPTH + 1) begin
      errors++;
      $display("FAIL dfull_count: got %0d beats want %0d", q_data.size(), PKT_DEPTH + 1);
    end
    for (int i = 0; i < q_data.size() && i < PKT_DEPTH + 1; i++) begin
      checks++;
      if ({q_data[i], q_sop[i], q_eop[i], q_id[i]} !== {8'h60 + 8'(i), 1'b1, 1'b1, 3'(i)}) begin
        errors++;
        $display("FAIL dfull_beat%0d: got data=%h sop=%0b eop=%0b id=%0d want data=%h",
                 i, q_data[i], q_sop[i], q_eop[i], q_id[i], 8'h60 + 8'(i));
      end
    end
  endtask

  task automatic test_proto_err();
    do_reset(1'b1);
    beat(8'h30, 1'b0, 1'b0, 1'b0, 3'd0);
    beat(8'h31, 1'b1, 1'b0, 1'b0, 3'd2);
    beat(8'h32, 1'b0, 1'b0, 1'b0, 3'd2);
    beat(8'h33, 1'b1, 1'b0, 1'b1, 3'd6);
    beat(8'h34, 1'b0, 1'b1, 1'b0, 3'd6);
    idle(6);
    checks++;
    if (err_cnt !== (STAT ? 16'd2 : 16'd0) || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL proto_counters: got err=%0d drop=%0d want err=%0d drop=0", err_cnt, drop_cnt,
               STAT ? 2 : 0);
    end
    checks++;
    if (q_data.size() !== 2) begin
      errors++;
      $display("FAIL proto_count: got %0d beats want 2", q_data.size());
    end
    for (int i = 0; i < q_data.size() && i < 2; i++) begin
      checks++;
      if ({q_data[i], q_sop[i], q_eop[i], q_id[i], q_qos[i]} !==
          {8'h33 + 8'(i), i == 0, i == 1, 3'd6, 1'b1}) begin
        errors++;
        $display("FAIL proto_beat%0d: got data=%h sop=%0b eop=%0b id=%0d qos=%0b want data=%h",
                 i, q_data[i], q_sop[i], q_eop[i], q_id[i], q_qos[i], 8'h33 + 8'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    beat(8'h3F, 1'b0, 1'b0, 1'b0, 3'd0);
    beat(8'h40, 1'b1, 1'b1, 1'b0, 3'd1);
    idle(3);
    checks++;
    if (out_vld !== 1'b1 || err_cnt !== (STAT ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL rmid_pre: got vld=%0b err=%0d want vld=1 err=%0d", out_vld, err_cnt,
               STAT ? 1 : 0);
    end
    beat(8'h41, 1'b1, 1'b0, 1'b0, 3'd2);
    beat(8'h42, 1'b0, 1'b0, 1'b0, 3'd2);
    rst = 1'b1;
    beat(8'h43, 1'b0, 1'b0, 1'b0, 3'd2);
    rst = 1'b0;
    in_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (out_vld !== 1'b0 || drop_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rmid_after: got vld=%0b drop=%0d err=%0d want 0 0 0", out_vld, drop_cnt,
               err_cnt);
    end
    tick();
    clear_q();
    out_rdy = 1'b1;
    beat(8'h50, 1'b1, 1'b0, 1'b1, 3'd3);
    beat(8'h51, 1'b0, 1'b1, 1'b0, 3'd3);
    idle(6);
    checks++;
    if (q_data.size() !== 2) begin
      errors++;
      $display("FAIL rmid_count: got %0d beats want 2", q_data.size());
    end
    for (int i = 0; i < q_data.size() && i < 2; i++) begin
      checks++;
      if ({q_data[i], q_sop[i], q_eop[i], q_id[i], q_qos[i]} !==
          {8'h50 + 8'(i), i == 0, i == 1, 3'd3, 1'b1}) begin
        errors++;
        $display("FAIL rmid_beat%0d: got data=%h sop=%0b eop=%0b id=%0d qos=%0b want data=%h",
                 i, q_data[i], q_sop[i], q_eop[i], q_id[i], q_qos[i], 8'h50 + 8'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_desc_full();
    test_proto_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
